// File: rtl/spi_flash_reader.sv
// SPI NOR flash reader: issues a READ (0x03) command with a 24-bit address and
// streams the returned bytes into a downstream FIFO, honouring FIFO backpressure.
`timescale 1ns/1ps
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_IDLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] start_addr,
    input  logic [15:0] byte_count,
    output logic        busy,
    output logic        done,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic        SPI_CLK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic        SPI_CS_n
);

    localparam logic [7:0] READ_CMD = 8'h03;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] CS_LAST  = 8'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        PUSH,
        CS_WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [7:0]  wait_cnt;
    logic [15:0] remaining;
    // Bits still to send after the one currently on SPI_MOSI; zero-filled so
    // MOSI falls to 0 by itself once the address is out.
    logic [30:0] tx_shift;

    // NOTE: the write strobe is decoded from the state register and fifo_full
    // in the same cycle, so a FIFO that fills up can never be written while full.
    assign fifo_wr_en = (state == PUSH) && !fifo_full;

    // NOTE: every register here is assigned with <= so all of them update together
    // on the edge; reset is synchronous and lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            SPI_CS_n     <= 1'b1;
            SPI_CLK      <= 1'b0;
            SPI_MOSI     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fifo_wr_data <= 8'h00;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            remaining    <= '0;
            tx_shift     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (byte_count == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= CMD;
                            SPI_CS_n  <= 1'b0;
                            SPI_MOSI  <= READ_CMD[7];
                            tx_shift  <= {READ_CMD[6:0], start_addr};
                            remaining <= byte_count;
                            div_cnt   <= '0;
                            bit_cnt   <= '0;
                        end
                    end
                end

                CMD, ADDR, DATA: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        SPI_CLK <= ~SPI_CLK;
                        if (!SPI_CLK) begin
                            if (state == DATA)
                                fifo_wr_data <= {fifo_wr_data[6:0], SPI_MISO};
                        end else begin
                            // Falling edge: present the next bit and close a phase when its bits are done.
                            bit_cnt  <= bit_cnt + 5'd1;
                            SPI_MOSI <= tx_shift[30];
                            tx_shift <= {tx_shift[29:0], 1'b0};
                            if (state == CMD && bit_cnt == 5'd7) begin
                                state   <= ADDR;
                                bit_cnt <= '0;
                            end else if (state == ADDR && bit_cnt == 5'd23) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else if (state == DATA && bit_cnt == 5'd7) begin
                                state   <= PUSH;
                                bit_cnt <= '0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                PUSH: begin
                    if (!fifo_full) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state    <= CS_WAIT;
                            SPI_CS_n <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            state   <= DATA;
                            div_cnt <= '0;
                        end
                    end
                end

                CS_WAIT: begin
                    if (wait_cnt == CS_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: a behavioural flash streams bytes on
// MISO, a bus monitor records SPI activity and FIFO writes, vectors are compared.
`timescale 1ns/1ps
module tb_spi_flash_reader;

    localparam int CLK_DIV = 2;
    localparam int CS_IDLE = 4;
    localparam int BUDGET  = 20000;

    typedef enum int { K_ONES, K_PAT, K_RAND } kind_t;

    typedef struct {
        logic [23:0] addr;
        logic [15:0] cnt;
        int          full_cyc;
        bit          poke;
        bit          rand_bp;
        kind_t       kind;
        int          exp_rises;
        int          exp_pushes;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] start_addr;
    logic [15:0] byte_count;
    logic        busy;
    logic        done;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n;

    always #5 clk = ~clk;

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .byte_count  (byte_count),
        .busy        (busy),
        .done        (done),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .SPI_CLK     (spi_clk),
        .SPI_MOSI    (spi_mosi),
        .SPI_MISO    (spi_miso),
        .SPI_CS_n    (spi_cs_n)
    );

    int checks = 0;
    int errors = 0;

    // Bytes the flash returns for the current read, in stream order.
    logic [7:0] flash_bytes [256];
    logic [7:0] push_q [$];
    int         rise_cnt    = 0;
    int         done_cnt    = 0;
    int         proto_err   = 0;
    int         cs_high_cnt = 0;
    int         last_gap    = 0;
    int         cs_fall_cnt = 0;
    logic [31:0] hdr = '0;
    logic prev_clk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic flash_bit(input int idx);
        logic [7:0] b;
        b = flash_bytes[(idx / 8) % 256];
        return b[7 - (idx % 8)];
    endfunction

    // Bus monitor and flash model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_cs && !spi_cs_n) begin
                last_gap = cs_high_cnt;
                rise_cnt = 0;
                hdr      = '0;
                cs_fall_cnt++;
            end
            cs_high_cnt = spi_cs_n ? cs_high_cnt + 1 : 0;
            if (!spi_cs_n && !prev_clk && spi_clk) begin
                if (rise_cnt < 32) hdr = {hdr[30:0], spi_mosi};
                else if (spi_mosi) proto_err++;
                rise_cnt++;
            end
            if (!spi_cs_n && prev_clk && !spi_clk && rise_cnt >= 32)
                spi_miso = flash_bit(rise_cnt - 32);
            if (spi_mosi !== prev_mosi && !(prev_clk && !spi_clk) && (prev_cs == spi_cs_n))
                proto_err++;
            if (spi_cs_n && spi_mosi) proto_err++;
            if (fifo_wr_en) push_q.push_back(fifo_wr_data);
            if (done) done_cnt++;
        end
        prev_clk  = spi_clk;
        prev_cs   = spi_cs_n;
        prev_mosi = spi_mosi;
    end

    task automatic fill_flash(input kind_t kind);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                K_ONES:  flash_bytes[i] = 8'hFF;
                K_PAT:   flash_bytes[i] = (i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'h00;
                default: flash_bytes[i] = 8'($urandom);
            endcase
        end
        spi_miso = (kind == K_ONES);
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] c);
        start_addr = a;
        byte_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        bit held  = 1'b0;
        bit poked = 1'b0;
        int froz  = 0;
        fill_flash(v.kind);
        push_q.delete();
        done_cnt  = 0;
        fifo_full = (v.full_cyc > 0);
        pulse_start(v.addr, v.cnt);
        check("busy_on_accept", busy, 1'b1);
        check("cs_low_on_accept", spi_cs_n, 1'b0);
        check("mosi_first_bit", spi_mosi, 1'b0);
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            tick();
            if (v.rand_bp) fifo_full = ($urandom_range(0, 2) == 0);
            if (v.full_cyc > 0 && !held && rise_cnt == 40 && !spi_clk) begin
                held = 1'b1;
                for (int k = 0; k < v.full_cyc; k++) begin
                    if (spi_clk || spi_cs_n || fifo_wr_en || rise_cnt != 40) froz++;
                    tick();
                end
                fifo_full = 1'b0;
            end
            if (v.poke && !poked && rise_cnt == 36) begin
                poked = 1'b1;
                pulse_start(~v.addr, v.cnt + 16'd3);
            end
            if (done_cnt != 0) break;
        end
        fifo_full = 1'b0;
        check("done_within_budget", done_cnt != 0, 1'b1);
        repeat (3) tick();
        check("done_pulses", done_cnt, 1);
        check("push_count", push_q.size(), v.exp_pushes);
        for (int i = 0; i < push_q.size() && i < v.exp_pushes; i++)
            check("push_data", push_q[i], flash_bytes[i]);
        check("spi_clk_rises", rise_cnt, v.exp_rises);
        check("mosi_header", hdr, {8'h03, v.addr});
        check("busy_after_done", busy, 1'b0);
        check("cs_high_after_done", spi_cs_n, 1'b1);
        check("cs_gap_min", last_gap >= CS_IDLE, 1'b1);
        if (v.full_cyc > 0) begin
            check("full_hold_reached", held, 1'b1);
            check("frozen_while_full", froz, 0);
        end
        if (v.poke) check("poke_applied", poked, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        vec_t rv;
        int   falls0;

        vecs[0] = '{24'h000100, 16'd2, 0,  1'b0, 1'b0, K_ONES, 48, 2};
        vecs[1] = '{24'hABCDEF, 16'd2, 0,  1'b0, 1'b0, K_PAT,  48, 2};
        vecs[2] = '{24'h123456, 16'd3, 20, 1'b0, 1'b0, K_RAND, 56, 3};
        vecs[3] = '{24'hFFFFFF, 16'd4, 0,  1'b1, 1'b0, K_RAND, 64, 4};
        vecs[4] = '{24'h000000, 16'd1, 0,  1'b0, 1'b1, K_RAND, 40, 1};

        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        byte_count = '0;
        fifo_full  = 1'b0;
        repeat (4) tick();
        check("reset_outputs",
              {spi_cs_n, spi_clk, spi_mosi, busy, done, fifo_wr_en, fifo_wr_data},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        repeat (6) tick();

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Zero-length read: done one cycle after start, chip select never falls.
        falls0 = cs_fall_cnt;
        push_q.delete();
        done_cnt = 0;
        pulse_start(24'h00BEEF, 16'd0);
        check("zero_done_pulse", done, 1'b1);
        check("zero_busy", busy, 1'b1);
        tick();
        check("zero_done_cleared", {done, busy}, 2'b00);
        repeat (10) tick();
        check("zero_done_count", done_cnt, 1);
        check("zero_no_push", push_q.size(), 0);
        check("zero_cs_never_low", cs_fall_cnt, falls0);

        // Reset while the address is being shifted out.
        fill_flash(K_RAND);
        pulse_start(24'h55AA55, 16'd3);
        for (int cyc = 0; cyc < BUDGET && rise_cnt < 12; cyc++) tick();
        check("reached_addr_phase", rise_cnt >= 12, 1'b1);
        rst = 1'b1;
        tick();
        check("rst_mid_addr", {spi_cs_n, spi_clk, busy, fifo_wr_en}, 4'b1000);
        rst = 1'b0;
        push_q.delete();
        done_cnt = 0;
        repeat (60) tick();
        check("rst_no_push", push_q.size(), 0);
        check("rst_no_done", done_cnt, 0);
        rv = '{24'h0ABC00, 16'd2, 0, 1'b0, 1'b0, K_RAND, 48, 2};
        run_txn(rv);

        // Randomised reads, half of them under random backpressure.
        for (int n = 0; n < 6; n++) begin
            rv.addr       = 24'($urandom);
            rv.cnt        = 16'($urandom_range(1, 6));
            rv.full_cyc   = 0;
            rv.poke       = 1'b0;
            rv.rand_bp    = n[0];
            rv.kind       = K_RAND;
            rv.exp_rises  = 32 + 8 * int'(rv.cnt);
            rv.exp_pushes = int'(rv.cnt);
            run_txn(rv);
        end

        check("protocol_violations", proto_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per SPI_CLK half-period; legal range 1..255.
REQ-002 SHALL have parameter CS_IDLE, default 4: minimum clk cycles SPI_CS_n stays high between transactions; legal range 1..255.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle request to begin a read; sampled only in IDLE.
REQ-007 start_addr  input  24  flash byte address; captured when start is accepted.
REQ-008 byte_count  input  16  number of bytes to read; captured when start is accepted.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  one-cycle pulse when the transaction completes.
REQ-011 fifo_full  input  1  downstream FIFO full flag (backpressure).
REQ-012 fifo_wr_en  output  1  one-cycle write strobe to the downstream FIFO.
REQ-013 fifo_wr_data  output  8  byte read from flash; valid while fifo_wr_en is high.
REQ-014 SPI_CLK  output  1  SPI serial clock, mode 0 (idle low).
REQ-015 SPI_MOSI  output  1  serial data to flash, MSB first.
REQ-016 SPI_MISO  input  1  serial data from flash, MSB first.
REQ-017 SPI_CS_n  output  1  active-low flash chip select.

Function
REQ-018 FSM states SHALL be: IDLE, CMD, ADDR, DATA, PUSH, CS_WAIT, DONE.
REQ-019 IDLE: start=1 and byte_count!=0 -> CMD next cycle, SPI_CS_n low and SPI_MOSI = bit 7 of 0x03 in that same cycle.
REQ-020 IDLE: start=1 and byte_count==0 -> DONE directly; SPI_CS_n never falls.
REQ-021 CMD SHALL shift out 0x03 (8 bits), then ADDR SHALL shift start_addr[23:0] (24 bits), then DATA SHALL read bytes.
REQ-022 SPI_CLK SHALL toggle every CLK_DIV clk cycles while shifting; one bit = 2*CLK_DIV clk cycles.
REQ-023 SPI_MOSI SHALL change only on SPI_CLK falling edges (or at CS_n fall for the first bit); SPI_MISO SHALL be sampled on SPI_CLK rising edges.
REQ-024 SPI_MOSI SHALL be 0 in DATA and whenever SPI_CS_n is high.
REQ-025 After 8 DATA bits, FSM SHALL enter PUSH with SPI_CLK held low; fifo_wr_en pulses in the first PUSH cycle with fifo_full=0.
REQ-026 While fifo_full=1 in PUSH, SPI_CLK SHALL stay low, SPI_CS_n stay low, fifo_wr_en stay low; no data lost or duplicated.
REQ-027 After a push: remaining bytes>0 -> DATA (next SPI_CLK rise CLK_DIV cycles later); else CS_WAIT.
REQ-028 CS_WAIT SHALL drive SPI_CS_n high for CS_IDLE cycles, then DONE.
REQ-029 DONE SHALL pulse done for one cycle and return to IDLE; busy low from that IDLE cycle.
REQ-030 start asserted while not in IDLE SHALL be ignored.
REQ-031 Remaining-byte counter SHALL be 16 bits, decremented once per push; 0xFFFF is legal and yields 65535 pushes.
REQ-032 Address is not incremented internally; flash auto-increments across the read; 24-bit wrap is the flash's concern.

Reset
REQ-033 On rst=1: state IDLE, SPI_CS_n=1, SPI_CLK=0, SPI_MOSI=0, busy=0, done=0, fifo_wr_en=0, fifo_wr_data=0x00, all counters 0.
REQ-034 rst mid-transaction SHALL take effect next rising edge: CS_n high, no further pushes, no done pulse.

Verification
REQ-035 CLK_DIV=2, start_addr=0x000100, byte_count=2, MISO tied 1 -> MOSI bytes 0x03,0x00,0x01,0x00; 48 SPI_CLK rises; two pushes of 0xFF; done once.
REQ-036 MISO driven with 0xA5 then 0x3C on SPI_CLK falling edges, byte_count=2 -> fifo_wr_data 0xA5 then 0x3C.
REQ-037 fifo_full=1 for 20 cycles at first PUSH -> SPI_CLK/CS_n frozen, single push of correct byte once fifo_full=0, transaction resumes.
REQ-038 byte_count=0 -> done pulses 1 cycle after start, SPI_CS_n stays high, no fifo_wr_en.
REQ-039 rst=1 during ADDR -> next cycle SPI_CS_n=1, SPI_CLK=0, busy=0; new start afterwards completes normally.
REQ-040 start pulsed during DATA -> ignored; byte and push counts unchanged; CS_n high >= CS_IDLE cycles between back-to-back transactions.
